// File: rtl/aes_iter_ctrl.sv
// Sequencing controller for an iterative AES-128 datapath with one shared round unit
// and an on-the-fly key schedule: accept -> load -> NUM_ROUNDS rounds -> capture -> output.
module aes_iter_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int ROUND_W    = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [0:127]       i_plain,
  input  logic [0:127]       i_key,
  output logic [0:127]       o_dp_plain,
  output logic [0:127]       o_dp_key,
  output logic               o_dp_load,
  output logic               o_dp_round_en,
  output logic [ROUND_W-1:0] o_dp_round,
  output logic               o_dp_final,
  output logic [7:0]         o_rcon,
  input  logic [0:127]       i_dp_state,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [0:127]       o_cipher,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_CAPTURE,
    S_OUT
  } state_t;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

  state_t             state_q, state_d;
  logic [0:127]       plain_q, plain_d;
  logic [0:127]       key_q, key_d;
  logic [0:127]       cipher_q, cipher_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [7:0]         rcon_q, rcon_d;
  logic               last_round;

  // GF(2^8) multiply-by-two; walks Rcon through 01,02,..,80,1B,36.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  assign last_round = (round_q == LAST_ROUND);

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (i_valid) state_d = S_LOAD;
      S_LOAD:    state_d = S_ROUND;
      S_ROUND:   if (last_round) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_OUT;
      S_OUT:     if (i_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Operand, counter, Rcon and result registers
  always_comb begin
    plain_d  = plain_q;
    key_d    = key_q;
    cipher_d = cipher_q;
    round_d  = round_q;
    rcon_d   = rcon_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          plain_d = i_plain;
          key_d   = i_key;
        end
      end
      S_LOAD: begin
        round_d = ROUND_W'(1);
        rcon_d  = 8'h01;
      end
      S_ROUND: begin
        // Park the counter at zero after the last round so it never wraps.
        if (last_round) begin
          round_d = '0;
          rcon_d  = 8'h00;
        end else begin
          round_d = round_q + ROUND_W'(1);
          rcon_d  = xtime(rcon_q);
        end
      end
      S_CAPTURE: cipher_d = i_dp_state;
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      plain_q  <= '0;
      key_q    <= '0;
      cipher_q <= '0;
      round_q  <= '0;
      rcon_q   <= '0;
    end else begin
      plain_q  <= plain_d;
      key_q    <= key_d;
      cipher_q <= cipher_d;
      round_q  <= round_d;
      rcon_q   <= rcon_d;
    end
  end

  // Output decode; ready is masked by reset so a request in the reset cycle is never taken.
  always_comb begin
    o_ready       = 1'b0;
    o_dp_load     = 1'b0;
    o_dp_round_en = 1'b0;
    o_dp_round    = '0;
    o_dp_final    = 1'b0;
    o_rcon        = 8'h00;
    o_valid       = 1'b0;
    o_busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  o_ready = !i_reset;
      S_LOAD:  o_dp_load = 1'b1;
      S_ROUND: begin
        o_dp_round_en = 1'b1;
        o_dp_round    = round_q;
        o_dp_final    = last_round;
        o_rcon        = rcon_q;
      end
      S_OUT:   o_valid = 1'b1;
      default: ;
    endcase
  end

  assign o_dp_plain = plain_q;
  assign o_dp_key   = key_q;
  assign o_cipher   = cipher_q;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Bench for aes_iter_ctrl: a behavioural AES round/key datapath driven by the controller's
// strobes, plus a cycle-count model of the expected handshake and strobe outputs.
module tb_aes_iter_ctrl;
  localparam int NR = 10;
  typedef logic [0:127] blk_t;

  localparam blk_t P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam blk_t K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam blk_t C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam blk_t P2 = 128'h00112233445566778899aabbccddeeff;
  localparam blk_t K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam blk_t C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_reset, i_valid, i_ready;
  blk_t       i_plain, i_key, i_dp_state;
  logic       o_ready, o_dp_load, o_dp_round_en, o_dp_final, o_valid, o_busy;
  blk_t       o_dp_plain, o_dp_key, o_cipher;
  logic [3:0] o_dp_round;
  logic [7:0] o_rcon;

  aes_iter_ctrl #(.NUM_ROUNDS(NR), .ROUND_W(4)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_plain(i_plain), .i_key(i_key), .o_dp_plain(o_dp_plain), .o_dp_key(o_dp_key),
    .o_dp_load(o_dp_load), .o_dp_round_en(o_dp_round_en), .o_dp_round(o_dp_round),
    .o_dp_final(o_dp_final), .o_rcon(o_rcon), .i_dp_state(i_dp_state),
    .o_valid(o_valid), .i_ready(i_ready), .o_cipher(o_cipher), .o_busy(o_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse (a^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
  endfunction

  function automatic blk_t sub_shift(input blk_t s);
    blk_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = sbox(s[8*(4*((c+r)%4)+r) +: 8]);
    return o;
  endfunction

  function automatic blk_t mix(input blk_t s);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(4*c) +: 8];
      a1 = s[8*(4*c+1) +: 8];
      a2 = s[8*(4*c+2) +: 8];
      a3 = s[8*(4*c+3) +: 8];
      o[8*(4*c) +: 8]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[8*(4*c+1) +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[8*(4*c+2) +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[8*(4*c+3) +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic blk_t key_step(input blk_t k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[0 +: 32];
    w1 = k[32 +: 32];
    w2 = k[64 +: 32];
    w3 = k[96 +: 32];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic blk_t aes_round(input blk_t s, input blk_t rk, input logic fin);
    blk_t t;
    t = sub_shift(s);
    if (!fin) t = mix(t);
    return t ^ rk;
  endfunction

  function automatic blk_t aes_encrypt(input blk_t p, input blk_t k);
    blk_t s, rk;
    logic [7:0] rc;
    s  = p ^ k;
    rk = k;
    rc = 8'h01;
    for (int r = 1; r <= NR; r++) begin
      rk = key_step(rk, rc);
      s  = aes_round(s, rk, r == NR);
      rc = xt(rc);
    end
    return s;
  endfunction

  // ---------------- datapath model driven by the controller strobes ----------------
  blk_t dp_rk;
  assign i_dp_state = dp_st;
  blk_t dp_st;
  always @(posedge clk) begin
    if (o_dp_load) begin
      dp_st <= o_dp_plain ^ o_dp_key;
      dp_rk <= o_dp_key;
    end else if (o_dp_round_en) begin
      dp_st <= aes_round(dp_st, key_step(dp_rk, o_rcon), o_dp_final);
      dp_rk <= key_step(dp_rk, o_rcon);
    end
  end

  // ---------------- expectation model: phase = edges since accept ----------------
  // 0 idle, 1 load, 2..NR+1 rounds, NR+2 capture, NR+3 output.
  logic [7:0] rcon_tab [NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int   m_phase = 0;
  blk_t m_plain = '0, m_key = '0, m_cipher = '0;
  int   cyc = 0;
  int   acc_q[$];
  blk_t out_q[$];
  logic [7:0] rc_log[$];
  logic [3:0] rd_log[$];
  logic       fin_log[$];
  int   load_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!i_reset && o_ready && i_valid) acc_q.push_back(cyc);
    if (i_reset) begin
      m_phase  <= 0;
      m_plain  <= '0;
      m_key    <= '0;
      m_cipher <= '0;
    end else if (m_phase == 0) begin
      if (i_valid) begin
        m_phase <= 1;
        m_plain <= i_plain;
        m_key   <= i_key;
      end
    end else if (m_phase == NR + 3) begin
      if (i_ready) m_phase <= 0;
    end else begin
      if (m_phase == NR + 2) m_cipher <= aes_encrypt(m_plain, m_key);
      m_phase <= m_phase + 1;
    end
  end

  // One compare process, every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("o_ready", 128'(o_ready), 128'(m_phase == 0 && !i_reset));
    if (!i_reset) begin
      chk("o_valid", 128'(o_valid), 128'(m_phase == NR + 3));
      chk("o_busy", 128'(o_busy), 128'(m_phase != 0));
      chk("o_dp_load", 128'(o_dp_load), 128'(m_phase == 1));
      chk("o_dp_round_en", 128'(o_dp_round_en), 128'(m_phase >= 2 && m_phase <= NR + 1));
      chk("o_dp_round", 128'(o_dp_round),
          (m_phase >= 2 && m_phase <= NR + 1) ? 128'(m_phase - 1) : 128'(0));
      chk("o_dp_final", 128'(o_dp_final), 128'(m_phase == NR + 1));
      chk("o_rcon", 128'(o_rcon),
          (m_phase >= 2 && m_phase <= NR + 1) ? 128'(rcon_tab[m_phase-2]) : 128'(0));
      chk("o_dp_plain", o_dp_plain, m_plain);
      chk("o_dp_key", o_dp_key, m_key);
      chk("o_cipher", o_cipher, m_cipher);
      if (o_dp_round_en) begin
        rc_log.push_back(o_rcon);
        rd_log.push_back(o_dp_round);
        fin_log.push_back(o_dp_final);
      end
      if (o_valid && i_ready) out_q.push_back(o_cipher);
      load_cnt <= load_cnt + int'(o_dp_load);
    end
  end

  // ---------------- stimulus helpers (inputs change 1 time unit after the edge) ----------------
  task automatic wait_busy(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!o_busy && n < 5);
    if (!o_busy) timeout(name);
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!o_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!o_valid) timeout(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, base, lbase, a0, o0;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_plain = '0;
    i_key   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_low", 128'(o_ready), 128'(0));
    i_reset = 1'b0;
    #1;
    chk("reset_ready_high", 128'(o_ready), 128'(1));
    chk("reset_busy", 128'(o_busy), 128'(0));
    chk("reset_valid", 128'(o_valid), 128'(0));
    chk("reset_cipher", o_cipher, 128'(0));
    chk("reset_dp_plain", o_dp_plain, 128'(0));

    // Test 1: FIPS-197 B vector, inputs scrambled after accept, then backpressure.
    base  = rc_log.size();
    lbase = load_cnt;
    i_plain = P1;
    i_key   = K1;
    i_valid = 1'b1;
    wait_busy("t1_accept");
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 40) begin
      i_plain = {$urandom, $urandom, $urandom, $urandom};
      i_key   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      n++;
    end
    chk("t1_latency", 128'(n), 128'(12));
    chk("t1_cipher", o_cipher, C1);
    chk("t1_dp_plain_held", o_dp_plain, P1);
    chk("t1_dp_key_held", o_dp_key, K1);
    chk("t1_load_pulses", 128'(load_cnt - lbase), 128'(1));
    chk("t1_round_cycles", 128'(rc_log.size() - base), 128'(10));
    for (int i = 0; i < NR; i++) begin
      if (base + i < rc_log.size()) begin
        chk("t1_rcon_seq", 128'(rc_log[base+i]), 128'(rcon_tab[i]));
        chk("t1_round_seq", 128'(rd_log[base+i]), 128'(i + 1));
        chk("t1_final_seq", 128'(fin_log[base+i]), 128'(i == NR - 1));
      end
    end
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 128'(o_valid), 128'(1));
      chk("bp_cipher", o_cipher, C1);
      chk("bp_ready", 128'(o_ready), 128'(0));
    end
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 128'(o_valid), 128'(0));
    chk("bp_release_ready", 128'(o_ready), 128'(1));

    // Test 2: back-to-back requests with i_valid held and i_ready tied high.
    a0 = acc_q.size();
    o0 = out_q.size();
    i_plain = P1;
    i_key   = K1;
    i_valid = 1'b1;
    wait_busy("t2_accept");
    i_plain = P2;
    i_key   = K2;
    n = 0;
    while (acc_q.size() < a0 + 2 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    if (acc_q.size() < a0 + 2) timeout("t2_second_accept");
    else chk("t2_spacing", 128'(acc_q[a0+1] - acc_q[a0]), 128'(14));
    n = 0;
    while (out_q.size() < o0 + 2 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (out_q.size() < o0 + 2) timeout("t2_outputs");
    else begin
      chk("t2_cipher_a", out_q[o0], C1);
      chk("t2_cipher_b", out_q[o0+1], C2);
    end

    // Test 3: reset at round 5, request held through the reset cycle, then completes.
    o0 = out_q.size();
    i_plain = P1;
    i_key   = K1;
    i_valid = 1'b1;
    wait_busy("t3_accept");
    i_valid = 1'b0;
    n = 0;
    while (o_dp_round != 4'd5 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (o_dp_round != 4'd5) timeout("t3_round5");
    i_reset = 1'b1;
    i_plain = P2;
    i_key   = K2;
    i_valid = 1'b1;
    #1;
    chk("t3_ready_in_reset", 128'(o_ready), 128'(0));
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    #1;
    chk("t3_idle_busy", 128'(o_busy), 128'(0));
    chk("t3_idle_valid", 128'(o_valid), 128'(0));
    chk("t3_idle_round_en", 128'(o_dp_round_en), 128'(0));
    chk("t3_idle_round", 128'(o_dp_round), 128'(0));
    chk("t3_idle_rcon", 128'(o_rcon), 128'(0));
    chk("t3_idle_dp_plain", o_dp_plain, 128'(0));
    chk("t3_idle_dp_key", o_dp_key, 128'(0));
    chk("t3_idle_cipher", o_cipher, 128'(0));
    chk("t3_ready_after", 128'(o_ready), 128'(1));
    wait_busy("t3_new_accept");
    i_valid = 1'b0;
    wait_valid("t3_valid", n);
    chk("t3_latency", 128'(n), 128'(12));
    chk("t3_cipher", o_cipher, C2);
    @(posedge clk);
    #1;
    chk("t3_single_output", 128'(out_q.size() - o0), 128'(1));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_iter_ctrl.md
Name: aes_iter_ctrl

Overview:
Sequencing controller for the iterative AES-128 encryption datapath, which has one shared round unit and one on-the-fly key-schedule unit.
- Accepts plaintext/key blocks over a valid/ready handshake and registers them.
- Issues the initial AddRoundKey load, then steps the round unit through NUM_ROUNDS rounds, supplying round index, final-round flag and Rcon.
- Captures the datapath state as ciphertext and presents it over an output valid/ready handshake.
- Sits between the request source and the round/key-schedule datapath. It replaces the fully unrolled aes_top in area-constrained builds.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds after the initial AddRoundKey; legal range 2..15 (AES-128 = 10).
ROUND_W, 4, width of round index; must hold NUM_ROUNDS.

Ports:
i_clock  input  1  system clock; all logic on rising edge.
i_reset  input  1  synchronous reset, active-high.
i_valid  input  1  request valid.
o_ready  output  1  controller accepts a request this cycle.
i_plain  input  [0:127]  plaintext, bit 0 = MSB of byte 0.
i_key  input  [0:127]  cipher key, same ordering.
o_dp_plain  output  [0:127]  registered plaintext to datapath.
o_dp_key  output  [0:127]  registered key to datapath.
o_dp_load  output  1  one-cycle pulse; datapath loads state = plain ^ key and key reg = key at the next edge.
o_dp_round_en  output  1  datapath performs one round at the next edge.
o_dp_round  output  [ROUND_W-1:0]  current round number, 1..NUM_ROUNDS; 0 when not in a round.
o_dp_final  output  1  high with round_en when round == NUM_ROUNDS (skip MixColumns).
o_rcon  output  8  Rcon byte for the key-schedule step of the current round.
i_dp_state  input  [0:127]  datapath state register.
o_valid  output  1  ciphertext valid.
i_ready  input  1  downstream accepts ciphertext.
o_cipher  output  [0:127]  ciphertext, held stable while o_valid.
o_busy  output  1  high in any state except IDLE.

Behaviour:
FSM states: IDLE, LOAD, ROUND, CAPTURE, OUT.

Per-state rules:
- IDLE: o_ready = 1.
  - On i_valid && o_ready, register i_plain/i_key into o_dp_plain/o_dp_key and go to LOAD.
- LOAD: o_dp_load = 1 for exactly one cycle. Round counter := 1, rcon := 8'h01, then go to ROUND.
- ROUND: o_dp_round_en = 1, o_dp_round = counter, o_rcon = rcon. o_dp_final = (counter == NUM_ROUNDS).
  - Each cycle: counter += 1; rcon := xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
  - Rcon sequence is 01,02,04,08,10,20,40,80,1B,36.
  - After the cycle with counter == NUM_ROUNDS, go to CAPTURE.
- CAPTURE: no datapath strobes. At the edge, o_cipher := i_dp_state, then go to OUT.
- OUT: o_valid = 1 and o_cipher stable.
  - On i_ready, go to IDLE.
  - While i_ready is low, hold indefinitely with no change to o_cipher.

Latency:
- Accept edge E0. Load edge E1. Round edges E2..E(NUM_ROUNDS+1). Capture edge E(NUM_ROUNDS+2).
- o_valid is high in the cycle after E(NUM_ROUNDS+2): 12 cycles after accept for 10 rounds.
- Minimum request spacing is 14 cycles, with i_ready tied high.

Handshake rules:
- o_ready is low in all non-IDLE states.
- i_valid outside IDLE is ignored; the source must hold the request.
- i_plain/i_key changing after acceptance has no effect on the current operation.
- o_valid and o_ready are never high in the same cycle.

Outputs outside their active state:
- o_dp_round = 0, o_dp_final = 0, o_dp_round_en = 0, o_dp_load = 0, o_rcon = 8'h00.

Reset (synchronous, also mid-operation):
- State goes to IDLE. All registered outputs clear to 0: o_dp_plain, o_dp_key, o_cipher, counter, rcon.
- o_valid = 0, o_busy = 0.
- o_ready = 0 while i_reset is high and 1 in the first cycle after deassertion.
- A request with i_valid in the reset cycle is not accepted.
- An operation in progress is abandoned, and no o_valid is produced for it.

Test Plan:
- FIPS-197 B vector, controller driving a behavioural round/key-schedule model: plain 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> o_cipher 3925841d02dc09fbdc118597196a0b32, o_valid 12 cycles after accept.
- Strobe check on the same run: o_dp_load is high for exactly 1 cycle; o_dp_round_en is high for 10 consecutive cycles with o_dp_round 1..10 and o_rcon 01,02,04,08,10,20,40,80,1B,36; o_dp_final is high only at round 10.
- Backpressure: i_ready held low 20 cycles after o_valid -> o_valid stays high, o_cipher unchanged, o_ready low; i_ready high -> o_valid drops next cycle and o_ready rises.
- Back-to-back: i_valid held high with two vectors (second: plain 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f) and i_ready high -> ciphers 3925841d... then 69c4e0d86a7b0430d8cdb78070b4c55a, with second accept 14 cycles after the first.
- Reset at round 5 -> the next cycle shows IDLE, all outputs 0, no o_valid; a new request after reset completes correctly.
- Input change during ROUND: i_plain/i_key toggled every cycle after accept -> o_dp_plain/o_dp_key and the result are unchanged.
